// File: rtl/breakout_pkg.sv
// Shared geometry constants and helpers for the breakout block column.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package breakout_pkg;

    localparam int COORD_W = 11;

    // Face indices into every 4-bit contact / bounce vector.
    localparam int FACE_U = 0;
    localparam int FACE_D = 1;
    localparam int FACE_L = 2;
    localparam int FACE_R = 3;

    // Top pixel row of block row r; defaults match the standard playfield.
    function automatic int row_top(input int r, input int y_top = 4, input int pitch = 23);
        return y_top + r * pitch;
    endfunction

endpackage

// File: rtl/breakout_block_column_if.sv
// Bundle of pixel/ball inputs and hit/score outputs of one block column.
// Latency: n/a (wiring only).
// Backpressure: none; all outputs are pulses or levels, no handshake.
interface breakout_block_column_if #(
    parameter int SCORE_W = 8
);
    import breakout_pkg::*;

    logic                 frame_tick;
    logic [COORD_W-1:0]   pix_x;
    logic [COORD_W-1:0]   pix_y;
    logic [COORD_W-1:0]   ball_l;
    logic [COORD_W-1:0]   ball_r;
    logic [COORD_W-1:0]   ball_t;
    logic [COORD_W-1:0]   ball_b;

    logic                 block_on;
    logic                 bounce_u;
    logic                 bounce_d;
    logic                 bounce_l;
    logic                 bounce_r;
    logic                 hit_valid;
    logic [3:0]           hit_row;
    logic [SCORE_W-1:0]   score;
    logic [4:0]           live_cnt;
    logic                 col_clear;

    // Game side: drives scan position and ball box, consumes hit results.
    modport master (
        output frame_tick, pix_x, pix_y, ball_l, ball_r, ball_t, ball_b,
        input  block_on, bounce_u, bounce_d, bounce_l, bounce_r,
        input  hit_valid, hit_row, score, live_cnt, col_clear
    );

    // Column side.
    modport slave (
        input  frame_tick, pix_x, pix_y, ball_l, ball_r, ball_t, ball_b,
        output block_on, bounce_u, bounce_d, bounce_l, bounce_r,
        output hit_valid, hit_row, score, live_cnt, col_clear
    );

endinterface

// File: rtl/breakout_block_cell.sv
// One breakable block: pixel hit test, 4-face ball contact detect, durability counter.
// Latency: pix_on/face combinational; durability updates one clk after dec.
// Backpressure: none; dec is honoured every cycle it is asserted.
module breakout_block_cell
    import breakout_pkg::*;
#(
    parameter int ROW       = 0,
    parameter int X_LEFT    = 235,
    parameter int X_RIGHT   = 340,
    parameter int Y_TOP     = 4,
    parameter int ROW_H     = 16,
    parameter int ROW_PITCH = 23,
    parameter int EDGE      = 3,
    parameter int HITS      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COORD_W-1:0] ball_l,
    input  logic [COORD_W-1:0] ball_r,
    input  logic [COORD_W-1:0] ball_t,
    input  logic [COORD_W-1:0] ball_b,
    input  logic               dec,
    output logic               live,
    output logic               last,
    output logic               pix_on,
    output logic [3:0]         face
);

    localparam int TOP = row_top(ROW, Y_TOP, ROW_PITCH);
    localparam int BOT = TOP + ROW_H - 1;

    localparam logic [COORD_W-1:0] XL   = COORD_W'(X_LEFT);
    localparam logic [COORD_W-1:0] XL_E = COORD_W'(X_LEFT + EDGE);
    localparam logic [COORD_W-1:0] XR   = COORD_W'(X_RIGHT);
    localparam logic [COORD_W-1:0] XR_E = COORD_W'(X_RIGHT - EDGE);
    localparam logic [COORD_W-1:0] YT   = COORD_W'(TOP);
    localparam logic [COORD_W-1:0] YT_E = COORD_W'(TOP + EDGE);
    localparam logic [COORD_W-1:0] YB   = COORD_W'(BOT);
    localparam logic [COORD_W-1:0] YB_E = COORD_W'(BOT - EDGE);

    logic [2:0] dur_q;
    logic [2:0] dur_d;
    logic       ovl_x;
    logic       ovl_y;

    assign live = (dur_q != 3'd0);
    assign last = (dur_q == 3'd1);

    // Geometry: pixel inside block, and which face bands the ball sits in.
    always_comb begin
        ovl_x  = (ball_r >= XL) && (ball_l <= XR);
        ovl_y  = (ball_b >= YT) && (ball_t <= YB);
        face   = 4'b0000;
        face[FACE_U] = live && ovl_x && (ball_b >= YT)   && (ball_b <= YT_E);
        face[FACE_D] = live && ovl_x && (ball_t >= YB_E) && (ball_t <= YB);
        face[FACE_L] = live && ovl_y && (ball_r >= XL)   && (ball_r <= XL_E);
        face[FACE_R] = live && ovl_y && (ball_l >= XR_E) && (ball_l <= XR);
        pix_on = live && (pix_x >= XL) && (pix_x <= XR) && (pix_y >= YT) && (pix_y <= YB);
    end

    // Next durability: one step down per accepted hit, never below zero.
    always_comb begin
        dur_d = dur_q;
        if (dec && (dur_q != 3'd0)) begin
            dur_d = dur_q - 3'd1;
        end
    end

    // Durability register, reloaded to full strength on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            dur_q <= 3'(HITS);
        end else begin
            dur_q <= dur_d;
        end
    end

endmodule

// File: rtl/breakout_block_column.sv
// Column of ROWS blocks: draws live blocks, arbitrates one hit per frame, scores kills.
// Latency: block_on 0 clk; ball box to bounce/hit_valid pulse 2 clk.
// Backpressure: none; extra contacts within a frame are dropped by the armed lockout.
module breakout_block_column
    import breakout_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int X_LEFT    = 235,
    parameter int X_RIGHT   = 340,
    parameter int Y_TOP     = 4,
    parameter int ROW_H     = 16,
    parameter int ROW_PITCH = 23,
    parameter int EDGE      = 3,
    parameter int HITS      = 1,
    parameter int POINTS    = 1,
    parameter int SCORE_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    breakout_block_column_if.slave  bus
);

    logic [ROWS-1:0]       live;
    logic [ROWS-1:0]       last;
    logic [ROWS-1:0]       pix_on;
    logic [ROWS-1:0]       dec;
    logic [ROWS-1:0][3:0]  face;

    logic [ROWS-1:0][3:0]  contact_q;
    logic [ROWS-1:0][3:0]  contact_d;
    logic                  armed_q,     armed_d;
    logic [3:0]            bounce_q,    bounce_d;
    logic                  hit_valid_q, hit_valid_d;
    logic [3:0]            hit_row_q,   hit_row_d;
    logic [SCORE_W-1:0]    score_q,     score_d;
    logic [4:0]            live_cnt_q,  live_cnt_d;
    logic                  col_clear_q, col_clear_d;

    logic                  hit;
    logic [3:0]            sel;
    logic [3:0]            sel_face;
    logic                  kill;
    logic [SCORE_W:0]      score_sum;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        breakout_block_cell #(
            .ROW      (r),
            .X_LEFT   (X_LEFT),
            .X_RIGHT  (X_RIGHT),
            .Y_TOP    (Y_TOP),
            .ROW_H    (ROW_H),
            .ROW_PITCH(ROW_PITCH),
            .EDGE     (EDGE),
            .HITS     (HITS)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .pix_x  (bus.pix_x),
            .pix_y  (bus.pix_y),
            .ball_l (bus.ball_l),
            .ball_r (bus.ball_r),
            .ball_t (bus.ball_t),
            .ball_b (bus.ball_b),
            .dec    (dec[r]),
            .live   (live[r]),
            .last   (last[r]),
            .pix_on (pix_on[r]),
            .face   (face[r])
        );
    end

    assign contact_d = face;

    // Stage 2 arbitration: lowest live row with registered contact wins.
    // The live mask drops stale contacts of a block killed one cycle earlier.
    always_comb begin
        hit      = 1'b0;
        sel      = 4'd0;
        sel_face = 4'b0000;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (armed_q && !col_clear_q && live[r] && (contact_q[r] != 4'b0000)) begin
                hit      = 1'b1;
                sel      = 4'(r);
                sel_face = contact_q[r];
            end
        end
    end

    // Route the accepted hit to its cell and detect a kill (last hit point).
    always_comb begin
        dec = '0;
        for (int r = 0; r < ROWS; r++) begin
            dec[r] = hit && (sel == 4'(r));
        end
        kill = |(dec & last);
    end

    // Next-state for pulses, lockout, score and live count.
    always_comb begin
        bounce_d    = hit ? sel_face : 4'b0000;
        hit_valid_d = hit;
        hit_row_d   = hit ? sel : hit_row_q;
        // frame_tick wins over a same-cycle hit so the next frame is armed.
        armed_d     = bus.frame_tick ? 1'b1 : (hit ? 1'b0 : armed_q);
        score_sum   = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);
        score_d     = score_q;
        live_cnt_d  = live_cnt_q;
        if (kill) begin
            score_d    = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
            live_cnt_d = live_cnt_q - 5'd1;
        end
        col_clear_d = col_clear_q | (live_cnt_q == 5'd0);
    end

    // Pipeline and column state registers; reset drops any in-flight contact.
    always_ff @(posedge clk) begin
        if (reset) begin
            contact_q   <= '0;
            armed_q     <= 1'b1;
            bounce_q    <= 4'b0000;
            hit_valid_q <= 1'b0;
            hit_row_q   <= 4'd0;
            score_q     <= '0;
            live_cnt_q  <= 5'(ROWS);
            col_clear_q <= 1'b0;
        end else begin
            contact_q   <= contact_d;
            armed_q     <= armed_d;
            bounce_q    <= bounce_d;
            hit_valid_q <= hit_valid_d;
            hit_row_q   <= hit_row_d;
            score_q     <= score_d;
            live_cnt_q  <= live_cnt_d;
            col_clear_q <= col_clear_d;
        end
    end

    assign bus.block_on  = |pix_on;
    assign bus.bounce_u  = bounce_q[FACE_U];
    assign bus.bounce_d  = bounce_q[FACE_D];
    assign bus.bounce_l  = bounce_q[FACE_L];
    assign bus.bounce_r  = bounce_q[FACE_R];
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_row   = hit_row_q;
    assign bus.score     = score_q;
    assign bus.live_cnt  = live_cnt_q;
    assign bus.col_clear = col_clear_q;

endmodule
